// File: rtl/seq_detect_ctrl.sv
// Frame-based serial pattern detector: consumes frame_len valid bits of x,
// pulses match per detection, counts detections, and pulses done at frame end.
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             overlap,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             done
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_reg, state_next;
  logic [PAT_W-1:0]   pattern_reg;
  logic [PAT_W-2:0]   hist_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   bits_reg;
  logic [FILL_W-1:0]  fill_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               overlap_reg;
  logic               overflow_reg;
  logic               match_reg;

  logic [PAT_W-1:0]   window;
  logic               consume;
  logic               detect;
  logic               last_bit;
  logic               accept;

  assign window  = {hist_reg, x};
  assign consume = (state_reg == RUN) && x_valid;
  assign accept  = (state_reg == IDLE) && start;
  // fill counts bits in the current window; PAT_W-1 stored plus x makes a full window
  assign detect  = consume && (fill_reg >= FILL_W'(PAT_W - 1)) && (window == pattern_reg);
  assign last_bit = consume &&
                    (({1'b0, bits_reg} + (LEN_W+1)'(1)) == {1'b0, len_reg});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (frame_len == '0) ? FIN : RUN;
      RUN:     if (last_bit) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_reg  <= '0;
      hist_reg     <= '0;
      len_reg      <= '0;
      bits_reg     <= '0;
      fill_reg     <= '0;
      count_reg    <= '0;
      overlap_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      match_reg    <= 1'b0;
    end else begin
      match_reg <= detect;
      if (accept) begin
        pattern_reg  <= pattern;
        len_reg      <= frame_len;
        overlap_reg  <= overlap;
        hist_reg     <= '0;
        bits_reg     <= '0;
        fill_reg     <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else if (consume) begin
        hist_reg <= window[PAT_W-2:0];
        bits_reg <= bits_reg + 1'b1;
        // non-overlapping mode restarts the window after a hit
        if (detect && !overlap_reg)            fill_reg <= '0;
        else if (fill_reg < FILL_W'(PAT_W))    fill_reg <= fill_reg + 1'b1;
        if (detect) begin
          if (count_reg == '1) overflow_reg <= 1'b1;
          else                 count_reg    <= count_reg + 1'b1;
        end
      end
    end
  end

  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == FIN);
  assign match       = match_reg;
  assign match_count = count_reg;
  assign overflow    = overflow_reg;

endmodule
